// File: rtl/scan_ctrl_pkg.sv
// rtl/scan_ctrl_pkg.sv - shared types and sizing helpers for the scan chain controller
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CAPT   = 3'd2,
        ST_UNLOAD = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Bit counter width: wide enough to hold N itself
    function automatic int CNT_W(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - load/capture/unload scan test controller with masked compare
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int N     = 8,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [N-1:0]     pat_data,
    input  logic [N-1:0]     pat_exp,
    input  logic [N-1:0]     pat_mask,
    output logic             scan,
    output logic             scan_data,
    input  logic             scan_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [N-1:0]     resp_data,
    output logic             resp_mismatch,
    output logic [ERR_W-1:0] err_cnt,
    output logic             busy
);

    localparam int CW = CNT_W(N);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_sh;
    logic [N-1:0]    r_exp;
    logic [N-1:0]    r_mask;
    logic [N-1:0]    r_resp;
    logic            r_scan;
    logic            r_sdata;
    logic            r_rvalid;
    logic            r_mm;
    logic [ERR_W-1:0] r_err;

    logic            w_accept;
    logic            w_last;
    logic [N-1:0]    w_resp_nxt;
    logic            w_mm_nxt;
    logic            w_scan_nxt;
    logic            w_sdata_nxt;

    assign w_accept   = pat_valid && (r_state == ST_IDLE);
    assign w_last     = (r_cnt == CW'(N - 1));
    assign w_resp_nxt = {r_resp[N-2:0], scan_out};
    assign w_mm_nxt   = |((w_resp_nxt ^ r_exp) & r_mask);

    assign pat_ready     = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign scan          = r_scan;
    assign scan_data     = r_sdata;
    assign resp_valid    = r_rvalid;
    assign resp_data     = r_resp;
    assign resp_mismatch = r_mm;
    assign err_cnt       = r_err;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode: LOAD and UNLOAD each run N cycles, CAPT one
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)   w_next = ST_LOAD;
            ST_LOAD:   if (w_last)     w_next = ST_CAPT;
            ST_CAPT:                   w_next = ST_UNLOAD;
            ST_UNLOAD: if (w_last)     w_next = ST_DONE;
            ST_DONE:   if (resp_ready) w_next = ST_IDLE;
            default:                   w_next = ST_IDLE;
        endcase
    end

    // Next values of the registered chain controls; stimulus goes out MSB first
    always_comb begin
        w_scan_nxt  = 1'b0;
        w_sdata_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_scan_nxt  = 1'b1;
                    w_sdata_nxt = pat_data[N-1];
                end
            end
            ST_LOAD: begin
                if (!w_last) begin
                    w_scan_nxt  = 1'b1;
                    w_sdata_nxt = r_sh[N-1];
                end
            end
            ST_CAPT:   w_scan_nxt = 1'b1;
            ST_UNLOAD: w_scan_nxt = !w_last;
            default: begin
                w_scan_nxt  = 1'b0;
                w_sdata_nxt = 1'b0;
            end
        endcase
    end

    // Datapath: pattern shifter, bit counter, response capture, compare and error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan   <= 1'b0;
            r_sdata  <= 1'b0;
            r_cnt    <= '0;
            r_sh     <= '0;
            r_exp    <= '0;
            r_mask   <= '0;
            r_resp   <= '0;
            r_rvalid <= 1'b0;
            r_mm     <= 1'b0;
            r_err    <= '0;
        end else begin
            r_scan  <= w_scan_nxt;
            r_sdata <= w_sdata_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sh   <= {pat_data[N-2:0], 1'b0};
                        r_exp  <= pat_exp;
                        r_mask <= pat_mask;
                        r_cnt  <= '0;
                    end
                end
                ST_LOAD: begin
                    r_sh  <= {r_sh[N-2:0], 1'b0};
                    r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                end
                ST_CAPT: r_cnt <= '0;
                ST_UNLOAD: begin
                    r_resp <= w_resp_nxt;
                    r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
                    if (w_last) begin
                        r_rvalid <= 1'b1;
                        r_mm     <= w_mm_nxt;
                        if (w_mm_nxt && (r_err != {ERR_W{1'b1}}))
                            r_err <= r_err + ERR_W'(1);
                    end
                end
                ST_DONE: begin
                    if (resp_ready) r_rvalid <= 1'b0;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - directed self-checking bench for scan_chain_ctrl with a modelled scan chain
module tb_scan_chain_ctrl;

    localparam int N     = 8;
    localparam int ERR_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pat_valid;
    logic             pat_ready;
    logic [N-1:0]     pat_data;
    logic [N-1:0]     pat_exp;
    logic [N-1:0]     pat_mask;
    logic             scan;
    logic             scan_data;
    logic             scan_out;
    logic             resp_valid;
    logic             resp_ready;
    logic [N-1:0]     resp_data;
    logic             resp_mismatch;
    logic [ERR_W-1:0] err_cnt;
    logic             busy;

    logic [N-1:0]     chain_q;
    logic             inv_mode;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    scan_chain_ctrl #(.N(N), .ERR_W(ERR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pat_valid     (pat_valid),
        .pat_ready     (pat_ready),
        .pat_data      (pat_data),
        .pat_exp       (pat_exp),
        .pat_mask      (pat_mask),
        .scan          (scan),
        .scan_data     (scan_data),
        .scan_out      (scan_out),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_mismatch (resp_mismatch),
        .err_cnt       (err_cnt),
        .busy          (busy)
    );

    // Scan register chain: shift when scan=1, otherwise load functional d (q or ~q)
    always_ff @(posedge clk) begin
        if (scan) chain_q <= {chain_q[N-2:0], scan_data};
        else      chain_q <= inv_mode ? ~chain_q : chain_q;
    end
    assign scan_out = chain_q[N-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_test(input logic [N-1:0] pat, input logic [N-1:0] expv,
                            input logic [N-1:0] mask, input logic [N-1:0] exp_resp,
                            input logic exp_mm, input logic [ERR_W-1:0] exp_err,
                            input int hold);
        logic [N-1:0] held;
        chk("idle_pat_ready", 32'(pat_ready), 32'd1);
        pat_valid = 1'b1;
        pat_data  = pat;
        pat_exp   = expv;
        pat_mask  = mask;
        tick();
        pat_valid = 1'b0;
        pat_data  = ~pat;
        pat_exp   = ~expv;
        pat_mask  = '0;
        for (int k = 0; k < N; k++) begin
            chk("load_scan", 32'(scan), 32'd1);
            chk("load_sdata", 32'(scan_data), 32'(pat[N-1-k]));
            tick();
        end
        chk("capt_scan", 32'(scan), 32'd0);
        chk("capt_sdata", 32'(scan_data), 32'd0);
        chk("capt_busy", 32'(busy), 32'd1);
        tick();
        for (int j = 0; j < N; j++) begin
            chk("unl_scan", 32'(scan), 32'd1);
            chk("unl_sdata", 32'(scan_data), 32'd0);
            chk("unl_rvalid", 32'(resp_valid), 32'd0);
            tick();
        end
        chk("done_rvalid", 32'(resp_valid), 32'd1);
        chk("done_resp", 32'(resp_data), 32'(exp_resp));
        chk("done_mm", 32'(resp_mismatch), 32'(exp_mm));
        chk("done_err", 32'(err_cnt), 32'(exp_err));
        chk("done_pat_ready", 32'(pat_ready), 32'd0);
        chk("done_scan", 32'(scan), 32'd0);
        held = resp_data;
        for (int h = 0; h < hold; h++) begin
            pat_valid = 1'b1;
            pat_data  = 8'hFF;
            tick();
            chk("bp_rvalid", 32'(resp_valid), 32'd1);
            chk("bp_resp", 32'(resp_data), 32'(held));
            chk("bp_pat_ready", 32'(pat_ready), 32'd0);
            chk("bp_scan", 32'(scan), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        pat_valid  = 1'b0;
        chk("ack_rvalid", 32'(resp_valid), 32'd0);
        chk("ack_pat_ready", 32'(pat_ready), 32'd1);
        chk("ack_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        pat_valid  = 1'b0;
        pat_data   = '0;
        pat_exp    = '0;
        pat_mask   = '0;
        resp_ready = 1'b0;
        inv_mode   = 1'b0;
        #1;
        chk("rst_pat_ready", 32'(pat_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_scan", 32'(scan), 32'd0);
        chk("rst_sdata", 32'(scan_data), 32'd0);
        chk("rst_rvalid", 32'(resp_valid), 32'd0);
        chk("rst_resp", 32'(resp_data), 32'd0);
        chk("rst_mm", 32'(resp_mismatch), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pat_ready2", 32'(pat_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Basic: identity chain
        run_test(8'hA5, 8'hA5, 8'hFF, 8'hA5, 1'b0, 2'd0, 0);

        // Inverting chain: match, then masked mismatch
        inv_mode = 1'b1;
        run_test(8'h3C, 8'hC3, 8'hFF, 8'hC3, 1'b0, 2'd0, 0);
        run_test(8'h3C, 8'hFF, 8'h0F, 8'hC3, 1'b1, 2'd1, 0);

        // Backpressure in DONE with pat_valid held high
        inv_mode = 1'b0;
        run_test(8'h96, 8'h96, 8'hFF, 8'h96, 1'b0, 2'd1, 5);

        // Reset during LOAD cycle 3
        pat_valid = 1'b1;
        pat_data  = 8'hC7;
        pat_exp   = 8'h00;
        pat_mask  = 8'hFF;
        tick();
        pat_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_scan", 32'(scan), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_scan", 32'(scan), 32'd0);
        chk("arst_sdata", 32'(scan_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_err", 32'(err_cnt), 32'd0);
        chk("arst_pat_ready", 32'(pat_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_test(8'h5A, 8'h5A, 8'hFF, 8'h5A, 1'b0, 2'd0, 0);

        // Zero mask never mismatches
        run_test(8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 2'd0, 0);
        run_test(8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0, 2'd0, 0);

        // Saturation of the 2-bit error counter
        run_test(8'h81, 8'h7E, 8'hFF, 8'h81, 1'b1, 2'd1, 0);
        run_test(8'h81, 8'h7E, 8'hFF, 8'h81, 1'b1, 2'd2, 0);
        run_test(8'h81, 8'h7E, 8'hFF, 8'h81, 1'b1, 2'd3, 0);
        run_test(8'h81, 8'h7E, 8'hFF, 8'h81, 1'b1, 2'd3, 0);
        run_test(8'h81, 8'h7E, 8'hFF, 8'h81, 1'b1, 2'd3, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Scan-test controller that drives the scan end of an N-bit scan register chain.
- Per test, it takes a stimulus pattern through a valid/ready handshake and serially loads it into the chain (scan=1).
- It then pulses one functional capture cycle (scan=0) and serially unloads the captured response from scan_out while filling the chain with zeros.
- It compares the response against an expected value under a mask, returns the result via valid/ready, and keeps a saturating error count.

Parameters:
- N, 8, chain length in bits; legal range N >= 2.
- ERR_W, 16, width of the saturating mismatch counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- pat_valid  input  1  new test offered
- pat_ready  output  1  controller can accept a test; high only in IDLE
- pat_data  input  N  stimulus to load into the chain
- pat_exp  input  N  expected captured response
- pat_mask  input  N  compare mask; 1 = bit compared
- scan  output  1  chain shift enable, registered
- scan_data  output  1  serial data into chain, registered
- scan_out  input  1  serial data from chain MSB
- resp_valid  output  1  response available
- resp_ready  input  1  consumer accepts response
- resp_data  output  N  captured response
- resp_mismatch  output  1  |((resp_data ^ exp) & mask)
- err_cnt  output  ERR_W  count of mismatching tests, saturating
- busy  output  1  state != IDLE

Behaviour:
- Reset and clock: clk is the clock; rst_n is asynchronous, active-low.
- Reset values: state=IDLE, scan=0, scan_data=0, resp_valid=0, resp_data=0, resp_mismatch=0, err_cnt=0, busy=0, bit counter=0.
- pat_ready is 1 during and after reset, because it is decoded from state==IDLE.
- Reset mid-operation aborts the test immediately. Chain contents are then undefined; no response is produced.
- States: IDLE, LOAD, CAPT, UNLOAD, DONE.
- IDLE:
  - Accept occurs at an edge with pat_valid & pat_ready.
  - On accept, latch pat_data, pat_exp and pat_mask; set scan<=1 and scan_data<=pat_data[N-1]; go to LOAD.
- LOAD:
  - Lasts exactly N cycles, with scan=1.
  - In LOAD cycle k (k=0..N-1), scan_data = pat_data[N-1-k], i.e. MSB first.
  - After N chain shifts, chain q == pat_data.
  - At the end of the last LOAD cycle, set scan<=0 and go to CAPT.
- CAPT:
  - Lasts exactly 1 cycle, with scan=0 and scan_data=0; the chain loads its functional d.
  - Then set scan<=1 and go to UNLOAD.
- UNLOAD:
  - Lasts exactly N cycles, with scan=1 and scan_data=0.
  - At each edge, sample resp <= {resp[N-2:0], scan_out}, so the captured MSB is sampled first.
  - After N samples, resp_data equals the captured chain value.
  - Then set scan<=0 and go to DONE.
  - On that same final edge, register resp_mismatch and increment err_cnt if mismatching. err_cnt holds at all-ones (saturates).
- DONE:
  - resp_valid=1; resp_data and resp_mismatch are held stable until resp_valid & resp_ready.
  - Then resp_valid<=0 and state goes to IDLE.
  - pat_ready rises the following cycle; there is no same-cycle re-accept.
- Latency:
  - The first scan=1 cycle is the cycle after the accept edge.
  - resp_valid rises exactly 2N+1 edges after the accept edge (N=8: 17).
- Other rules:
  - The bit counter is $clog2(N+1) bits wide and counts 0..N-1 in LOAD and in UNLOAD.
  - pat_* inputs are ignored outside the accept edge.
  - resp_ready is ignored outside DONE.
  - A mask of all zeros always gives mismatch=0.

Decomposition:
- Package scan_ctrl_pkg holds:
  - the state enum (IDLE/LOAD/CAPT/UNLOAD/DONE);
  - a CNT_W function computing $clog2(N+1).
- No sub-module; a single FSM with datapath registers.
- The bench pairs the DUT with the team's scan_reg chain, with scan_reg's d driven by a bench-controlled function of q.

Test Plan:
- Basic test (N=8, chain d=q):
  - Stimulus: accept pat 0xA5, exp 0xA5, mask 0xFF.
  - Required response: scan high for cycles 1-8, low for cycle 9, high for cycles 10-17; scan_data sequence 1,0,1,0,0,1,0,1; resp_valid at edge 17; resp_data=0xA5; mismatch=0; err_cnt=0.
- Inverting chain (d=~q):
  - Stimulus: pat 0x3C, exp 0xC3.
  - Required response: resp_data 0xC3, mismatch 0.
  - Stimulus: next test pat 0x3C, exp 0xFF, mask 0x0F.
  - Required response: resp_data 0xC3, mismatch 1, err_cnt=1.
- Backpressure:
  - Stimulus: hold resp_ready=0 for 5 cycles in DONE while pat_valid=1.
  - Required response: resp_valid and resp_data stable, pat_ready=0, scan=0 throughout; accept on the 6th cycle; pat_ready=1 the next cycle.
- Reset mid-LOAD:
  - Stimulus: assert rst_n=0 during LOAD cycle 3.
  - Required response: scan, scan_data, busy and err_cnt go to 0 asynchronously; pat_ready=1.
  - Stimulus: run a new test after release.
  - Required response: that test completes correctly with 0x5A.
- Saturation (ERR_W=2):
  - Stimulus: 5 consecutive mismatching tests.
  - Required response: err_cnt sequence 1,2,3,3,3.
- Mask and edge patterns:
  - Stimulus: pat 0x00 and pat 0xFF with mask 0x00 and wrong exp.
  - Required response: mismatch 0; no err_cnt increment.
